// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
//   Shared types and helpers for the packet DMA stream packer.
//   - state_t    : engine state (IDLE, RUN, DRAIN, DONE)
//   - calc_ratio : number of input beats per output word (OUT_W / IN_W)
//   - sat_inc32  : 32-bit increment that sticks at all-ones
// ---------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Beats per output word; also the width of the per-word keep mask.
  function automatic int calc_ratio(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

  // Status counters must not wrap back to zero on very long packets.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// ---------------------------------------------------------------------------
// dma_sync_fifo
//   Single-clock first-word-fall-through FIFO used as the packer's output
//   word buffer. The head entry is visible on data_o whenever empty_o is low
//   and stays put until it is popped.
//
// Ports
//   clk      in   clock
//   rst      in   async reset, active-high (pointers only)
//   clr_i    in   synchronous clear: empties the FIFO at the next edge,
//                 overriding any push/pop in the same cycle
//   push_i   in   write data_i (ignored when full unless a pop frees a slot)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   drop the head entry (ignored when empty)
//   data_o   out  head entry (undefined content when empty)
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module dma_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the
  // address bits are equal.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is accepted when the head leaves in the same
  // cycle; the occupancy simply stays at DEPTH.
  assign do_push = push_i && (!full_o || do_pop);

  // Storage carries no reset: only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dma_stream_packer.sv
// ---------------------------------------------------------------------------
// dma_stream_packer
//   Packet DMA: accepts IN_W-bit beats, packs them little-endian into
//   OUT_W-bit words (beat 0 in the low lane) and queues the words in an
//   output FIFO together with a lane keep mask and a packet-last flag.
//   A packet's trailing partial word is flushed with its unfilled lanes
//   zeroed.
//
// Ports
//   clk, rst        clock; async active-high reset
//   cfg_enable      engine enable; dropping it in RUN/DRAIN aborts the packet
//   cfg_start       start pulse, honoured only in IDLE
//   cfg_pkt_len     packet length in input beats, latched on accepted start
//   in_data/in_valid/in_ready     input beat stream
//   out_data/out_keep/out_last/out_valid/out_ready   output word stream
//   dma_busy        engine not in IDLE
//   dma_done        one-cycle pulse once the packet has fully drained
//   dma_error       sticky: zero-length start, abort or stall timeout;
//                   cleared by the next accepted start
//   dma_beats_in    beats accepted this packet (saturating)
//   dma_words_out   words handed downstream this packet (saturating)
//   dbg_state       current engine state (state_t encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid source holds its payload stable until that edge;
// ready may be asserted independently of valid.
//
// Build option: define DMA_PACK_TIMEOUT_EN to add a stall counter in RUN
// that aborts the packet after TIMEOUT_CYC consecutive cycles without
// in_valid. Without it, RUN waits for input indefinitely.
// ---------------------------------------------------------------------------
module dma_stream_packer
  import dma_pkg::*;
#(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int RATIO      = calc_ratio(OUT_W, IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_enable,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_pkt_len,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [RATIO-1:0] out_keep,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dma_busy,
  output logic             dma_done,
  output logic             dma_error,
  output logic [31:0]      dma_beats_in,
  output logic [31:0]      dma_words_out,
  output logic [1:0]       dbg_state
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WORD_W = OUT_W + RATIO + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t            state_q;
  logic [LEN_W-1:0]  rem_q;        // beats still to accept in this packet
  logic [LANE_W-1:0] lane_cnt_q;   // next lane to fill in the word under construction
  logic [OUT_W-1:0]  lanes_q;      // word under construction (unfilled lanes are 0)
  logic [RATIO-1:0]  keep_q;       // lanes filled so far
  logic [31:0]       beats_in_q;
  logic [31:0]       words_out_q;
  logic              error_q;

  // -------------------------------------------------------------------------
  // Combinational datapath
  // -------------------------------------------------------------------------
  logic              lane_full;
  logic              final_beat;
  logic              in_ready_w;
  logic              beat_fire;
  logic              abort;
  logic              timeout_hit;
  logic [OUT_W-1:0]  word_data_d;
  logic [RATIO-1:0]  word_keep_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_wdata;
  logic [WORD_W-1:0] fifo_rdata;

  assign lane_full  = (lane_cnt_q == LAST_LANE);
  assign final_beat = (rem_q == LEN_W'(1));

  // A beat that completes a word pushes in the same cycle, so it can only be
  // taken when the FIFO has room. The final beat of a packet also pushes,
  // whatever lane it lands in, hence the same guard applies to it.
  assign in_ready_w = (state_q == RUN) && !((lane_full || final_beat) && fifo_full);
  assign beat_fire  = in_valid && in_ready_w;

  // Word as it looks with the current beat merged into lane lane_cnt_q.
  assign word_data_d = lanes_q | (OUT_W'(in_data) << (int'(lane_cnt_q) * IN_W));
  assign word_keep_d = keep_q | (RATIO'(1) << lane_cnt_q);

  assign fifo_push  = beat_fire && (lane_full || final_beat);
  assign fifo_wdata = {final_beat, word_keep_d, word_data_d};
  assign fifo_pop   = out_ready && !fifo_empty;

  assign abort    = ((state_q == RUN) || (state_q == DRAIN)) && (!cfg_enable || timeout_hit);
  // Abort discards everything queued: the FIFO empties at the same edge
  // that returns the engine to IDLE.
  assign fifo_clr = abort;

  // -------------------------------------------------------------------------
  // Optional stall timeout
  // -------------------------------------------------------------------------
`ifdef DMA_PACK_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q;   // consecutive RUN cycles without in_valid

  // Fires in the cycle that would make the count reach TIMEOUT_CYC, so the
  // abort edge is exactly TIMEOUT_CYC idle cycles after the last beat.
  assign timeout_hit = (state_q == RUN) && !in_valid &&
                       (stall_q == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q != RUN) || beat_fire) begin
      stall_q <= '0;
    end else if (!in_valid) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // -------------------------------------------------------------------------
  // Engine FSM, packer lanes and status counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      lane_cnt_q  <= '0;
      lanes_q     <= '0;
      keep_q      <= '0;
      beats_in_q  <= '0;
      words_out_q <= '0;
      error_q     <= 1'b0;
    end else begin
      // Words leave the FIFO independently of the engine state; a start in
      // IDLE below overrides this with the counter clear.
      if (fifo_pop) begin
        words_out_q <= sat_inc32(words_out_q);
      end

      case (state_q)
        IDLE: begin
          if (cfg_start && cfg_enable) begin
            if (cfg_pkt_len != '0) begin
              state_q     <= RUN;
              rem_q       <= cfg_pkt_len;
              lane_cnt_q  <= '0;
              lanes_q     <= '0;
              keep_q      <= '0;
              beats_in_q  <= '0;
              words_out_q <= '0;
              error_q     <= 1'b0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end

        RUN: begin
          if (abort) begin
            state_q    <= IDLE;
            error_q    <= 1'b1;
            lane_cnt_q <= '0;
            lanes_q    <= '0;
            keep_q     <= '0;
          end else if (beat_fire) begin
            beats_in_q <= sat_inc32(beats_in_q);
            rem_q      <= rem_q - LEN_W'(1);
            if (fifo_push) begin
              // Word handed to the FIFO: start the next one from clean lanes.
              lane_cnt_q <= '0;
              lanes_q    <= '0;
              keep_q     <= '0;
            end else begin
              lane_cnt_q <= lane_cnt_q + LANE_W'(1);
              lanes_q    <= word_data_d;
              keep_q     <= word_keep_d;
            end
            if (final_beat) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            error_q <= 1'b1;
          end else if (fifo_empty) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output word buffer
  // -------------------------------------------------------------------------
  dma_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Outputs (all derived from registered state)
  // -------------------------------------------------------------------------
  assign in_ready      = in_ready_w;
  assign out_valid     = !fifo_empty;
  // Payload is forced to zero while nothing is queued so the output bus
  // never shows stale storage.
  assign out_data      = fifo_empty ? '0 : fifo_rdata[OUT_W-1:0];
  assign out_keep      = fifo_empty ? '0 : fifo_rdata[OUT_W +: RATIO];
  assign out_last      = !fifo_empty && fifo_rdata[WORD_W-1];
  assign dma_busy      = (state_q != IDLE);
  assign dma_done      = (state_q == DONE);
  assign dma_error     = error_q;
  assign dma_beats_in  = beats_in_q;
  assign dma_words_out = words_out_q;
  assign dbg_state     = state_q;

endmodule
